// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - opcode, queue entry and functional-unit class types
package lc3b_types;

    localparam int NUM_RS_DEFAULT   = 4;
    localparam int RS_DEPTH_DEFAULT = 4;

    typedef logic [3:0] lc3b_opcode;

    localparam lc3b_opcode OP_BR   = 4'b0000;
    localparam lc3b_opcode OP_ADD  = 4'b0001;
    localparam lc3b_opcode OP_LDB  = 4'b0010;
    localparam lc3b_opcode OP_STB  = 4'b0011;
    localparam lc3b_opcode OP_JSR  = 4'b0100;
    localparam lc3b_opcode OP_AND  = 4'b0101;
    localparam lc3b_opcode OP_LDW  = 4'b0110;
    localparam lc3b_opcode OP_STW  = 4'b0111;
    localparam lc3b_opcode OP_RTI  = 4'b1000;
    localparam lc3b_opcode OP_NOT  = 4'b1001;
    localparam lc3b_opcode OP_LDI  = 4'b1010;
    localparam lc3b_opcode OP_STI  = 4'b1011;
    localparam lc3b_opcode OP_JMP  = 4'b1100;
    localparam lc3b_opcode OP_SHF  = 4'b1101;
    localparam lc3b_opcode OP_LEA  = 4'b1110;
    localparam lc3b_opcode OP_TRAP = 4'b1111;

    typedef struct packed {
        lc3b_opcode  opcode;
        logic [11:0] operand;
        logic [15:0] pc;
    } lc3b_iqueue_entry;

    typedef enum logic [$clog2(NUM_RS_DEFAULT)-1:0] {
        ALU  = 2'd0,
        MEM  = 2'd1,
        BR   = 2'd2,
        MISC = 2'd3
    } lc3b_fu_class;

    // Each opcode maps to the reservation station that executes it; RTI is the odd one out.
    function automatic lc3b_fu_class fu_class_of(input lc3b_opcode op);
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA:         return ALU;
            OP_LDB, OP_LDW, OP_LDI, OP_STB, OP_STW, OP_STI: return MEM;
            OP_BR, OP_JMP, OP_JSR, OP_TRAP:                 return BR;
            default:                                        return MISC;
        endcase
    endfunction

endpackage

// File: rtl/macros.sv
// rtl/macros.sv - shared preprocessor constants for the dispatch slice
`ifndef BITS_OF_ROB_TAG
`define BITS_OF_ROB_TAG 3
`endif

// File: rtl/rs_credit_counter.sv
// rtl/rs_credit_counter.sv - free-slot credit tracker for one reservation station
module rs_credit_counter #(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] credit,
    output logic          nonzero,
    output logic          err
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] credit_q, credit_d;

    // Next credit: flush refills and drops returns; a simultaneous return and take cancel out.
    always_comb begin
        credit_d = credit_q;
        err      = 1'b0;
        if (flush) begin
            credit_d = FULL;
        end else if (inc && !dec) begin
            if (credit_q == FULL) begin
                err = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end else if (dec && !inc) begin
            credit_d = credit_q - CW'(1);
        end
    end

    // Credit register, full on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= FULL;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit  = credit_q;
    assign nonzero = (credit_q != '0);

endmodule

// File: rtl/dispatch_scheduler.sv
// rtl/dispatch_scheduler.sv - pops the instruction queue head into one reservation station per cycle
`ifndef BITS_OF_ROB_TAG
`define BITS_OF_ROB_TAG 3
`endif

module dispatch_scheduler
    import lc3b_types::*;
#(
    parameter int NUM_RS   = NUM_RS_DEFAULT,
    parameter int RS_DEPTH = RS_DEPTH_DEFAULT,
    parameter int TAG_BITS = `BITS_OF_ROB_TAG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  lc3b_iqueue_entry      iq_data,
    input  logic                  iq_valid,
    output logic                  iq_stalled,
    input  logic                  rob_full,
    input  logic [NUM_RS-1:0]     rs_credit_ret,
    output logic [NUM_RS-1:0]     rs_load,
    output lc3b_iqueue_entry      rs_data,
    output logic [TAG_BITS-1:0]   rs_tag,
    output logic                  credit_err
);

    localparam int CREDIT_W = $clog2(RS_DEPTH + 1);

    lc3b_fu_class        cls;
    logic                go;
    logic [NUM_RS-1:0]   nonzero_vec;
    logic [NUM_RS-1:0]   dec_vec;
    logic [NUM_RS-1:0]   err_vec;
    logic [CREDIT_W-1:0] credit_vec [NUM_RS];

    logic [NUM_RS-1:0]   rs_load_q, rs_load_d;
    lc3b_iqueue_entry    rs_data_q, rs_data_d;
    logic [TAG_BITS-1:0] rs_tag_q, rs_tag_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic                credit_err_q, credit_err_d;

    assign cls        = fu_class_of(iq_data.opcode);
    assign go         = !rst && iq_valid && !rob_full && !flush && nonzero_vec[cls];
    assign iq_stalled = !go;

    for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
        assign dec_vec[i] = go && (cls == lc3b_fu_class'(i));

        rs_credit_counter #(
            .DEPTH   (RS_DEPTH)
        ) u_credit (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .inc     (rs_credit_ret[i]),
            .dec     (dec_vec[i]),
            .credit  (credit_vec[i]),
            .nonzero (nonzero_vec[i]),
            .err     (err_vec[i])
        );

        a_credit_bound: assert property (@(posedge clk) disable iff (rst)
            credit_vec[i] <= CREDIT_W'(RS_DEPTH));
    end

    // Dispatch slot and tag allocation: load one RS on go, flush rewinds the tag counter.
    always_comb begin
        rs_load_d    = '0;
        rs_data_d    = rs_data_q;
        rs_tag_d     = rs_tag_q;
        tag_d        = tag_q;
        credit_err_d = credit_err_q | (|err_vec);
        if (flush) begin
            tag_d = '0;
        end else if (go) begin
            rs_load_d = NUM_RS'(1) << cls;
            rs_data_d = iq_data;
            rs_tag_d  = tag_q;
            tag_d     = tag_q + TAG_BITS'(1);
        end
    end

    // Dispatch state registers; credit_err is cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_load_q    <= '0;
            rs_data_q    <= '0;
            rs_tag_q     <= '0;
            tag_q        <= '0;
            credit_err_q <= 1'b0;
        end else begin
            rs_load_q    <= rs_load_d;
            rs_data_q    <= rs_data_d;
            rs_tag_q     <= rs_tag_d;
            tag_q        <= tag_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign rs_load    = rs_load_q;
    assign rs_data    = rs_data_q;
    assign rs_tag     = rs_tag_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb/tb_dispatch_scheduler.sv - directed self-checking bench for dispatch_scheduler
module tb_dispatch_scheduler;
    import lc3b_types::*;

    logic             clk;
    logic             rst;
    logic             flush;
    lc3b_iqueue_entry iq_data;
    logic             iq_valid;
    logic             iq_stalled;
    logic             rob_full;
    logic [3:0]       rs_credit_ret;
    logic [3:0]       rs_load;
    lc3b_iqueue_entry rs_data;
    logic [2:0]       rs_tag;
    logic             credit_err;

    int n_checks = 0;
    int n_fail   = 0;

    dispatch_scheduler #(
        .NUM_RS        (4),
        .RS_DEPTH      (4),
        .TAG_BITS      (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .iq_data       (iq_data),
        .iq_valid      (iq_valid),
        .iq_stalled    (iq_stalled),
        .rob_full      (rob_full),
        .rs_credit_ret (rs_credit_ret),
        .rs_load       (rs_load),
        .rs_data       (rs_data),
        .rs_tag        (rs_tag),
        .credit_err    (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        flush         = 1'b0;
        iq_valid      = 1'b0;
        iq_data       = '0;
        rob_full      = 1'b0;
        rs_credit_ret = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    function automatic lc3b_iqueue_entry mk(input lc3b_opcode op, input logic [15:0] pc);
        lc3b_iqueue_entry e;
        e.opcode  = op;
        e.operand = 12'h0a5 ^ pc[11:0];
        e.pc      = pc;
        return e;
    endfunction

    // Present one head that must pop, then check the registered slot one edge later.
    task automatic disp(input lc3b_opcode op, input logic [15:0] pc, input logic [3:0] exp_load,
                        input logic [2:0] exp_tag, input string tag);
        lc3b_iqueue_entry e;
        e        = mk(op, pc);
        iq_data  = e;
        iq_valid = 1'b1;
        #1;
        check_eq({tag, "_stall"}, 64'(iq_stalled), 64'(0));
        cyc();
        check_eq({tag, "_load"}, 64'(rs_load), 64'(exp_load));
        check_eq({tag, "_tag"},  64'(rs_tag),  64'(exp_tag));
        check_eq({tag, "_data"}, 64'(rs_data), 64'(e));
    endtask

    // Hold a head that must not pop and confirm the slot stays empty.
    task automatic expect_stall(input lc3b_opcode op, input logic [2:0] held_tag, input string tag);
        iq_data  = mk(op, 16'hdead);
        iq_valid = 1'b1;
        #1;
        check_eq({tag, "_stall"}, 64'(iq_stalled), 64'(1));
        cyc();
        check_eq({tag, "_load"}, 64'(rs_load), 64'(0));
        check_eq({tag, "_tag"},  64'(rs_tag),  64'(held_tag));
    endtask

    lc3b_opcode rot_ops [4] = '{OP_ADD, OP_LDW, OP_BR, OP_RTI};

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        iq_valid      = 1'b0;
        iq_data       = '0;
        rob_full      = 1'b0;
        rs_credit_ret = '0;
        cyc();
        check_eq("rst_load",  64'(rs_load),    64'(0));
        check_eq("rst_data",  64'(rs_data),    64'(0));
        check_eq("rst_tag",   64'(rs_tag),     64'(0));
        check_eq("rst_err",   64'(credit_err), 64'(0));
        iq_valid = 1'b1;
        iq_data  = mk(OP_ADD, 16'h1);
        #1;
        check_eq("rst_stall", 64'(iq_stalled), 64'(1));
        do_reset();

        // ALU, MEM, BR back to back
        disp(OP_ADD, 16'h3000, 4'b0001, 3'd0, "t1_alu");
        disp(OP_LDW, 16'h3002, 4'b0010, 3'd1, "t1_mem");
        disp(OP_JMP, 16'h3004, 4'b0100, 3'd2, "t1_br");
        iq_valid = 1'b0;
        cyc();
        check_eq("t1_idle_load", 64'(rs_load), 64'(0));
        check_eq("t1_idle_tag",  64'(rs_tag),  64'(2));

        // ALU credits run out after four, a return lets the fifth through
        do_reset();
        for (int k = 0; k < 4; k++)
            disp(OP_ADD, 16'(16'h100 + k), 4'b0001, 3'(k), $sformatf("t2_d%0d", k));
        expect_stall(OP_ADD, 3'd3, "t2_empty");
        rs_credit_ret = 4'b0001;
        expect_stall(OP_ADD, 3'd3, "t2_ret");
        rs_credit_ret = 4'b0000;
        disp(OP_AND, 16'h0200, 4'b0001, 3'd4, "t2_fifth");
        iq_valid = 1'b0;

        // Same-cycle dispatch and return at credit 2 leaves credit at 2
        do_reset();
        disp(OP_ADD, 16'h10, 4'b0001, 3'd0, "t3_a");
        disp(OP_ADD, 16'h11, 4'b0001, 3'd1, "t3_b");
        rs_credit_ret = 4'b0001;
        disp(OP_NOT, 16'h12, 4'b0001, 3'd2, "t3_both");
        rs_credit_ret = 4'b0000;
        disp(OP_SHF, 16'h13, 4'b0001, 3'd3, "t3_c");
        disp(OP_LEA, 16'h14, 4'b0001, 3'd4, "t3_d");
        expect_stall(OP_ADD, 3'd4, "t3_empty");
        iq_valid = 1'b0;

        // rob_full blocks the pop and keeps the tag
        do_reset();
        disp(OP_ADD, 16'h20, 4'b0001, 3'd0, "t4_a");
        rob_full = 1'b1;
        expect_stall(OP_STW, 3'd0, "t4_full");
        rob_full = 1'b0;
        disp(OP_STW, 16'h21, 4'b0010, 3'd1, "t4_after");
        iq_valid = 1'b0;

        // Tag wraps after eight dispatches
        do_reset();
        for (int k = 0; k < 9; k++)
            disp(rot_ops[k % 4], 16'(16'h400 + k), 4'(1 << (k % 4)), 3'(k % 8), $sformatf("t5_d%0d", k));
        iq_valid = 1'b0;

        // Flush with credits 1/2/4/3 and a same-cycle return
        do_reset();
        for (int k = 0; k < 3; k++)
            disp(OP_ADD, 16'(16'h500 + k), 4'b0001, 3'(k), $sformatf("t6_alu%0d", k));
        disp(OP_LDB, 16'h510, 4'b0010, 3'd3, "t6_mem0");
        disp(OP_STB, 16'h511, 4'b0010, 3'd4, "t6_mem1");
        disp(OP_RTI, 16'h520, 4'b1000, 3'd5, "t6_misc");
        flush         = 1'b1;
        rs_credit_ret = 4'b0010;
        expect_stall(OP_ADD, 3'd5, "t6_flush");
        flush         = 1'b0;
        rs_credit_ret = 4'b0000;
        check_eq("t6_err_clean", 64'(credit_err), 64'(0));
        for (int k = 0; k < 4; k++)
            disp(OP_ADD, 16'(16'h600 + k), 4'b0001, 3'(k), $sformatf("t6_post%0d", k));
        expect_stall(OP_ADD, 3'd3, "t6_post_empty");

        // Return to a full BR station is an error that survives flush
        iq_valid      = 1'b0;
        rs_credit_ret = 4'b0100;
        cyc();
        rs_credit_ret = 4'b0000;
        check_eq("t6_err_set", 64'(credit_err), 64'(1));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check_eq("t6_err_flush", 64'(credit_err), 64'(1));

        // Async reset in the middle of a dispatch
        disp(OP_BR, 16'h700, 4'b0100, 3'd0, "t7_br");
        disp(OP_TRAP, 16'h701, 4'b0100, 3'd1, "t7_trap");
        rst = 1'b1;
        #1;
        check_eq("t7_async_load",  64'(rs_load),    64'(0));
        check_eq("t7_async_tag",   64'(rs_tag),     64'(0));
        check_eq("t7_async_data",  64'(rs_data),    64'(0));
        check_eq("t7_async_err",   64'(credit_err), 64'(0));
        check_eq("t7_async_stall", 64'(iq_stalled), 64'(1));
        cyc();
        rst      = 1'b0;
        iq_valid = 1'b0;
        disp(OP_ADD, 16'h800, 4'b0001, 3'd0, "t7_after");
        iq_valid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
